x7seg_scan_decoder: RTL and testbench

// - Receive side of the multiplexed 7-segment scan bus (a_to_g active-low, an active-low).
// - Watches the scan, waits until each digit slot is stable, and decodes the segment

---
 rtl/x7seg_scan_decoder.sv | 248 ++++++++++++++++++++++++
 tb/tb_x7seg_scan_decoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x7seg_scan_decoder.sv
// +----------------------------------------------------------------------------+
// | x7seg_scan_decoder: recovers per-digit character codes from a multiplexed   |
// | 7-segment scan bus. Optional hex outputs: X7SEG_DEC_HEXOUT_EN. Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module x7seg_scan_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  a_to_g,
  input  logic [7:0]  an,
  output logic [39:0] digit_codes,
  output logic [7:0]  blank,
  output logic        cap_valid,
  output logic [2:0]  cap_idx,
  output logic        frame_done,
  output logic        err
`ifdef X7SEG_DEC_HEXOUT_EN
  ,
  output logic [31:0] hex_value,
  output logic        hex_ok
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_CAPTURED = 2'd2;

  logic [7:0]       an_s_q, an_s_d;
  logic [6:0]       seg_s_q, seg_s_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lat_an_q, lat_an_d;
  logic [6:0]       lat_seg_q, lat_seg_d;
  logic [39:0]      codes_q, codes_d;
  logic [7:0]       blank_q, blank_d;
  logic [7:0]       seen_q, seen_d;
  logic [2:0]       last_idx_q, last_idx_d;
  logic             have_last_q, have_last_d;
  logic             cap_valid_q, cap_valid_d;
  logic [2:0]       cap_idx_q, cap_idx_d;
  logic             frame_done_q, frame_done_d;
  logic             err_q, err_d;
  logic             multi_prev_q, multi_prev_d;

  logic [7:0] w_zeros;
  logic       w_one_zero;
  logic       w_multi;
  logic       w_same;
  logic [2:0] w_lat_idx;
  logic       w_eval_idle;
  logic       w_capture;

  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    case (p)
      7'h40: decode_seg = 5'h00;
      7'h79: decode_seg = 5'h01;
      7'h24: decode_seg = 5'h02;
      7'h30: decode_seg = 5'h03;
      7'h19: decode_seg = 5'h04;
      7'h12: decode_seg = 5'h05;
      7'h02: decode_seg = 5'h06;
      7'h78: decode_seg = 5'h07;
      7'h00: decode_seg = 5'h08;
      7'h10: decode_seg = 5'h09;
      7'h08: decode_seg = 5'h0A;
      7'h03: decode_seg = 5'h0B;
      7'h46: decode_seg = 5'h0C;
      7'h21: decode_seg = 5'h0D;
      7'h06: decode_seg = 5'h0E;
      7'h0E: decode_seg = 5'h0F;
      7'h0B: decode_seg = 5'h10;
      7'h09: decode_seg = 5'h13;
      7'h7F: decode_seg = 5'h1F;
      default: decode_seg = 5'h1E;
    endcase
  endfunction

  assign w_zeros    = ~an_s_q;
  assign w_one_zero = (w_zeros != 8'h00) && ((w_zeros & (w_zeros - 8'd1)) == 8'h00);
  assign w_multi    = (w_zeros != 8'h00) && !w_one_zero;
  assign w_same     = (an_s_q == lat_an_q) && (seg_s_q == lat_seg_q);

  always_comb begin
    w_lat_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!lat_an_q[i]) w_lat_idx = 3'(i);
    end
  end

  always_comb begin
    an_s_d       = an;
    seg_s_d      = a_to_g;
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_an_d     = lat_an_q;
    lat_seg_d    = lat_seg_q;
    codes_d      = codes_q;
    blank_d      = blank_q;
    seen_d       = seen_q;
    last_idx_d   = last_idx_q;
    have_last_d  = have_last_q;
    cap_valid_d  = 1'b0;
    cap_idx_d    = cap_idx_q;
    frame_done_d = 1'b0;
    // A multi-select an reads as an error in every state; flag only its onset
    // so a held fault yields one pulse instead of a level.
    err_d        = w_multi && !multi_prev_q;
    multi_prev_d = w_multi;
    w_eval_idle  = 1'b0;
    w_capture    = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        if (w_same) begin
          if (cnt_q == CNT_LAST) begin
            w_capture = 1'b1;
            state_d   = ST_CAPTURED;
          end else if (cnt_q < CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          w_eval_idle = 1'b1;
        end
      end
      ST_CAPTURED: begin
        if (!w_same) w_eval_idle = 1'b1;
      end
      default: w_eval_idle = 1'b1;
    endcase

    if (w_eval_idle) begin
      if (w_one_zero) begin
        state_d   = ST_SETTLE;
        cnt_d     = '0;
        lat_an_d  = an_s_q;
        lat_seg_d = seg_s_q;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (w_capture) begin
      // Wrapping back to a lower or equal slot closes the frame; the capture
      // itself is applied afterwards so it overrides the blanking of its slot.
      if (have_last_q && (w_lat_idx <= last_idx_q)) begin
        frame_done_d = 1'b1;
        blank_d      = ~seen_q;
        for (int i = 0; i < 8; i++) begin
          if (!seen_q[i]) codes_d[i*5 +: 5] = 5'h1F;
        end
        seen_d = 8'h00;
      end
      seen_d[w_lat_idx] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (i == int'(w_lat_idx)) codes_d[i*5 +: 5] = decode_seg(lat_seg_q);
      end
      cap_valid_d = 1'b1;
      cap_idx_d   = w_lat_idx;
      last_idx_d  = w_lat_idx;
      have_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s_q       <= 8'hFF;
      seg_s_q      <= 7'h7F;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lat_an_q     <= 8'hFF;
      lat_seg_q    <= 7'h7F;
      codes_q      <= {8{5'h1F}};
      blank_q      <= 8'hFF;
      seen_q       <= 8'h00;
      last_idx_q   <= 3'd0;
      have_last_q  <= 1'b0;
      cap_valid_q  <= 1'b0;
      cap_idx_q    <= 3'd0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      multi_prev_q <= 1'b0;
    end else begin
      an_s_q       <= an_s_d;
      seg_s_q      <= seg_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_an_q     <= lat_an_d;
      lat_seg_q    <= lat_seg_d;
      codes_q      <= codes_d;
      blank_q      <= blank_d;
      seen_q       <= seen_d;
      last_idx_q   <= last_idx_d;
      have_last_q  <= have_last_d;
      cap_valid_q  <= cap_valid_d;
      cap_idx_q    <= cap_idx_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      multi_prev_q <= multi_prev_d;
    end
  end

  assign digit_codes = codes_q;
  assign blank       = blank_q;
  assign cap_valid   = cap_valid_q;
  assign cap_idx     = cap_idx_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;

`ifdef X7SEG_DEC_HEXOUT_EN
  logic [31:0] hex_value_q, hex_value_d;
  logic        hex_ok_q, hex_ok_d;

  // Blank slots (code 1F) do not spoil hex_ok; only real non-hex glyphs do.
  always_comb begin
    hex_value_d = 32'h0;
    hex_ok_d    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (codes_d[i*5 +: 5] <= 5'h0F) begin
        hex_value_d[i*4 +: 4] = codes_d[i*5 +: 4];
      end else if (codes_d[i*5 +: 5] != 5'h1F) begin
        hex_ok_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_value_q <= 32'h0;
      hex_ok_q    <= 1'b1;
    end else begin
      hex_value_q <= hex_value_d;
      hex_ok_q    <= hex_ok_d;
    end
  end

  assign hex_value = hex_value_q;
  assign hex_ok    = hex_ok_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_x7seg_scan_decoder.sv
// Testbench for x7seg_scan_decoder (STABLE_CYCLES=4): directed tables plus
// randomized scan traffic against a run-length reference model.
`default_nettype none

module tb_x7seg_scan_decoder;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  a_to_g = 7'h7F;
  logic [7:0]  an = 8'hFF;
  logic [39:0] digit_codes;
  logic [7:0]  blank;
  logic        cap_valid;
  logic [2:0]  cap_idx;
  logic        frame_done;
  logic        err;
`ifdef X7SEG_DEC_HEXOUT_EN
  logic [31:0] hex_value;
  logic        hex_ok;
`endif

  x7seg_scan_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .a_to_g(a_to_g), .an(an),
    .digit_codes(digit_codes), .blank(blank), .cap_valid(cap_valid),
    .cap_idx(cap_idx), .frame_done(frame_done), .err(err)
`ifdef X7SEG_DEC_HEXOUT_EN
    , .hex_value(hex_value), .hex_ok(hex_ok)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_cap = 0, n_fd = 0, n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference glyph table: pattern k decodes to pcode[k].
  logic [6:0] pat [18] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
                           7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h0B, 7'h09};
  logic [4:0] pcode [18] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
                             5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h13};

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    if (p == 7'h7F) return 5'h1F;
    for (int k = 0; k < 18; k++) if (pat[k] == p) return pcode[k];
    return 5'h1E;
  endfunction

  function automatic int nzero(input logic [7:0] a);
    return $countones(~a);
  endfunction

  function automatic int zero_pos(input logic [7:0] a);
    for (int k = 0; k < 8; k++) if (!a[k]) return k;
    return 0;
  endfunction

  // Model: a slot is captured exactly when a single-select sample has been seen
  // on STABLE_CYCLES+1 consecutive register samples.
  logic [7:0]  m_an;
  logic [6:0]  m_seg;
  int          m_run;
  bit          m_pm;
  logic [7:0]  m_seen;
  int          m_last;
  bit          m_have;
  logic [39:0] e_codes;
  logic [7:0]  e_blank;
  logic        e_cap, e_fd, e_err;
  logic [2:0]  e_idx;

  task automatic model_reset();
    m_an = 8'hFF; m_seg = 7'h7F; m_run = 1; m_pm = 0; m_seen = 8'h00;
    m_last = 0; m_have = 0; e_codes = {8{5'h1F}}; e_blank = 8'hFF;
    e_cap = 0; e_fd = 0; e_err = 0; e_idx = 3'd0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        int idx;
        e_cap = 0;
        e_fd  = 0;
        e_err = (nzero(m_an) > 1) && !m_pm;
        m_pm  = nzero(m_an) > 1;
        if (nzero(m_an) == 1 && m_run == SC + 1) begin
          idx = zero_pos(m_an);
          if (m_have && idx <= m_last) begin
            e_fd = 1;
            for (int k = 0; k < 8; k++) begin
              e_blank[k] = !m_seen[k];
              if (!m_seen[k]) e_codes[5*k +: 5] = 5'h1F;
            end
            m_seen = 8'h00;
          end
          m_seen[idx] = 1'b1;
          e_codes[5*idx +: 5] = ref_decode(m_seg);
          e_cap = 1; e_idx = 3'(idx); m_last = idx; m_have = 1;
        end
        if (an == m_an && a_to_g == m_seg) begin
          if (m_run < 1000) m_run++;
        end else begin
          m_run = 1;
        end
        m_an = an; m_seg = a_to_g;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        chk("cycle_outputs", {13'h0, digit_codes, blank, cap_valid, frame_done, err},
            {13'h0, e_codes, e_blank, e_cap, e_fd, e_err});
        if (e_cap) chk("cap_idx", 64'(cap_idx), 64'(e_idx));
`ifdef X7SEG_DEC_HEXOUT_EN
        begin
          logic [31:0] hv;
          logic ok;
          hv = 32'h0; ok = 1'b1;
          for (int k = 0; k < 8; k++) begin
            if (e_codes[5*k +: 5] <= 5'h0F) hv[4*k +: 4] = e_codes[5*k +: 4];
            else if (e_codes[5*k +: 5] != 5'h1F) ok = 1'b0;
          end
          chk("hex_outputs", {31'h0, hex_value, hex_ok}, {31'h0, hv, ok});
        end
`endif
      end
      n_cap += int'(cap_valid);
      n_fd  += int'(frame_done);
      n_err += int'(err);
    end
  end

  task automatic slot(input logic [7:0] a, input logic [6:0] s, input int n);
    an = a; a_to_g = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    an = 8'hFF; a_to_g = 7'h7F;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    n_cap = 0; n_fd = 0; n_err = 0;
  endtask

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic [4:0] code;
  } vec_t;

  vec_t vecs [10];
  logic [39:0] exp40;

  initial begin
    vecs[0] = '{8'hFE, 7'h7E, 5'h1E};
    vecs[1] = '{8'hFD, 7'h0B, 5'h10};
    vecs[2] = '{8'hFB, 7'h09, 5'h13};
    vecs[3] = '{8'hF7, 7'h7F, 5'h1F};
    vecs[4] = '{8'hEF, 7'h0E, 5'h0F};
    vecs[5] = '{8'hDF, 7'h46, 5'h0C};
    vecs[6] = '{8'hBF, 7'h21, 5'h0D};
    vecs[7] = '{8'h7F, 7'h03, 5'h0B};
    vecs[8] = '{8'hFE, 7'h10, 5'h09};
    vecs[9] = '{8'hFD, 7'h08, 5'h0A};

    do_reset();
    chk("reset_codes", 64'(digit_codes), 64'({8{5'h1F}}));
    chk("reset_misc", {54'h0, blank, cap_valid, frame_done, err}, {54'h0, 8'hFF, 3'b000});
    chk("reset_idx", 64'(cap_idx), 64'h0);

    // Full 8-digit scan, two frames.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) slot(8'hFF ^ (8'h01 << i), pat[i], 40);
    for (int i = 0; i < 8; i++) exp40[5*i +: 5] = 5'(i);
    chk("scan_codes", 64'(digit_codes), 64'(exp40));
    chk("scan_blank", 64'(blank), 64'h00);
    chk("scan_frames", 64'(n_fd), 64'd1);

    // Only digits 0 and 1 driven.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      slot(8'hFE, 7'h40, 40);
      slot(8'hFD, 7'h79, 40);
    end
    chk("partial_blank", 64'(blank), 64'hFC);
    chk("partial_codes", 64'(digit_codes), 64'({{6{5'h1F}}, 5'h01, 5'h00}));

    // Unstable slot, then exactly STABLE_CYCLES+1 stable samples.
    do_reset();
    slot(8'hFE, 7'h40, 3);
    slot(8'hFE, 7'h79, 5);
    slot(8'hFF, 7'h7F, 10);
    chk("glitch_caps", 64'(n_cap), 64'd1);
    chk("glitch_code", 64'(digit_codes[4:0]), 64'h01);

    // Two anodes low.
    do_reset();
    slot(8'hFC, 7'h40, 6);
    slot(8'hFF, 7'h7F, 4);
    chk("multi_err", 64'(n_err), 64'd1);
    chk("multi_caps", 64'(n_cap), 64'd0);

    // Decode table vectors.
    do_reset();
    for (int v = 0; v < 10; v++) begin
      int p;
      slot(vecs[v].an, vecs[v].seg, 8);
      slot(8'hFF, 7'h7F, 2);
      p = zero_pos(vecs[v].an);
      chk($sformatf("vec%0d_code", v), 64'(digit_codes[5*p +: 5]), 64'(vecs[v].code));
    end

    // Asynchronous reset in the middle of a settle window.
    do_reset();
    slot(8'hFD, 7'h79, 8);
    slot(8'hFE, 7'h40, 3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_codes", 64'(digit_codes), 64'({8{5'h1F}}));
    chk("midrst_misc", {51'h0, blank, cap_valid, frame_done, err, cap_idx},
        {51'h0, 8'hFF, 3'b000, 3'd0});
    @(negedge clk);
    an = 8'hFF; a_to_g = 7'h7F;
    @(negedge clk);
    rst = 1'b0;
    n_cap = 0; n_fd = 0; n_err = 0;
    slot(8'hFF, 7'h7F, 6);
    chk("midrst_pulses", 64'(n_cap + n_fd + n_err), 64'd0);

`ifdef X7SEG_DEC_HEXOUT_EN
    do_reset();
    for (int i = 0; i < 4; i++) slot(8'hFF ^ (8'h01 << i), pat[i+1], 40);
    slot(8'hFE, pat[1], 40);
    chk("hex_value", 64'(hex_value), 64'h00004321);
    chk("hex_ok", 64'(hex_ok), 64'd1);
`endif

    // Randomized scan traffic; the per-cycle model check does the work here.
    do_reset();
    for (int it = 0; it < 400; it++) begin
      logic [7:0] a;
      logic [6:0] s;
      int r, b1, b2;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        a = 8'hFF;
      end else if (r == 2) begin
        b1 = $urandom_range(0, 7);
        b2 = (b1 + $urandom_range(1, 7)) % 8;
        a = ~((8'h01 << b1) | (8'h01 << b2));
      end else begin
        a = 8'hFF ^ (8'h01 << $urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) < 7) s = pat[$urandom_range(0, 17)];
      else s = 7'($urandom);
      slot(a, s, $urandom_range(1, 10));
    end
    slot(8'hFF, 7'h7F, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
